dmem_arbiter: RTL and testbench

- Two-requester arbiter and sequencer for the single-port data memory (dataMemory / genericRAM).
- Shares the memory between the CPU load/store port and a debug/program-loader port.
- Read latency is 1 cycle: the RAM registers the address, so data appears the cycle after the grant.
- Round-robin arbitration, a debug hold mode bounded by a starvation counter, and a registered read-return tag steering the response to the correct requester.

---
 rtl/dmem_arbiter_if.sv | 46 ++++
 rtl/dmem_arbiter.sv | 94 +++++++++
 tb/tb_dmem_arbiter.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester and RAM-side signal bundle for the data memory arbiter
interface dmem_arbiter_if #(
    parameter int dataW = 32,
    parameter int addrW = 16
);
    logic             cpuReq;
    logic             cpuWE;
    logic [addrW-1:0] cpuAddr;
    logic [dataW-1:0] cpuWData;
    logic             cpuGnt;
    logic             cpuRValid;
    logic [dataW-1:0] cpuRData;

    logic             dbgReq;
    logic             dbgWE;
    logic             dbgHold;
    logic [addrW-1:0] dbgAddr;
    logic [dataW-1:0] dbgWData;
    logic             dbgGnt;
    logic             dbgRValid;
    logic [dataW-1:0] dbgRData;

    logic [addrW-1:0] memAddr;
    logic [dataW-1:0] memDataW;
    logic             memRW;
    logic [dataW-1:0] memDataR;

    // Environment view: both requesters plus the RAM
    modport master (
        output cpuReq, cpuWE, cpuAddr, cpuWData,
        input  cpuGnt, cpuRValid, cpuRData,
        output dbgReq, dbgWE, dbgHold, dbgAddr, dbgWData,
        input  dbgGnt, dbgRValid, dbgRData,
        input  memAddr, memDataW, memRW,
        output memDataR
    );

    modport slave (
        input  cpuReq, cpuWE, cpuAddr, cpuWData,
        output cpuGnt, cpuRValid, cpuRData,
        input  dbgReq, dbgWE, dbgHold, dbgAddr, dbgWData,
        output dbgGnt, dbgRValid, dbgRData,
        output memAddr, memDataW, memRW,
        input  memDataR
    );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin CPU/debug arbiter for the single-port data RAM
module dmem_arbiter #(
    parameter int dataW    = 32,
    parameter int addrW    = 16,
    parameter int HOLD_MAX = 8
) (
    input logic           sysCLK,
    input logic           sysRST,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DBG  = 2'd2
    } owner_t;

    localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX);

    owner_t     lastOwner, ownerNext;
    logic [3:0] holdCnt, holdNext;
    logic       cpuWin, dbgWin;
    logic       rdValid, rdDbg;
    logic       rdValidNext;

    always_ff @(posedge sysCLK) begin
        if (sysRST) begin
            lastOwner <= OWN_IDLE;
            holdCnt   <= 4'd0;
            rdValid   <= 1'b0;
            rdDbg     <= 1'b0;
        end else begin
            lastOwner <= ownerNext;
            holdCnt   <= holdNext;
            rdValid   <= rdValidNext;
            rdDbg     <= dbgWin;
        end
    end

    always_comb begin
        cpuWin      = 1'b0;
        dbgWin      = 1'b0;
        ownerNext   = lastOwner;
        holdNext    = holdCnt;
        rdValidNext = 1'b0;

        // Grants are suppressed while reset is held so nothing commits mid-reset
        if (!sysRST) begin
            if (bus.cpuReq && bus.dbgReq) begin
                if (lastOwner == OWN_DBG && bus.dbgHold && holdCnt < HOLD_LIM)
                    dbgWin = 1'b1;
                else if (lastOwner == OWN_CPU)
                    dbgWin = 1'b1;
                else
                    cpuWin = 1'b1;
            end else if (bus.cpuReq) begin
                cpuWin = 1'b1;
            end else if (bus.dbgReq) begin
                dbgWin = 1'b1;
            end
        end

        if (cpuWin) ownerNext = OWN_CPU;
        if (dbgWin) ownerNext = OWN_DBG;

        // Starvation counter only runs while the CPU is actually waiting
        if (!bus.cpuReq || cpuWin)
            holdNext = 4'd0;
        else if (dbgWin && holdCnt < HOLD_LIM)
            holdNext = holdCnt + 4'd1;

        rdValidNext = (cpuWin && !bus.cpuWE) || (dbgWin && !bus.dbgWE);
    end

    always_comb begin
        bus.memAddr  = bus.cpuAddr;
        bus.memDataW = bus.cpuWData;
        bus.memRW    = 1'b0;
        if (cpuWin) begin
            bus.memRW = bus.cpuWE;
        end else if (dbgWin) begin
            bus.memAddr  = bus.dbgAddr;
            bus.memDataW = bus.dbgWData;
            bus.memRW    = bus.dbgWE;
        end
    end

    assign bus.cpuGnt    = cpuWin;
    assign bus.dbgGnt    = dbgWin;
    // A tag still in flight when reset arrives is swallowed, not returned
    assign bus.cpuRValid = rdValid && !rdDbg && !sysRST;
    assign bus.dbgRValid = rdValid && rdDbg && !sysRST;
    assign bus.cpuRData  = bus.memDataR;
    assign bus.dbgRData  = bus.memDataR;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed scoreboard bench for dmem_arbiter
module tb_dmem_arbiter;
    localparam int DW = 32;
    localparam int AW = 16;

    logic sysCLK = 1'b0;
    logic sysRST = 1'b1;
    always #5 sysCLK = ~sysCLK;

    dmem_arbiter_if #(.dataW(DW), .addrW(AW)) bus ();

    dmem_arbiter #(.dataW(DW), .addrW(AW), .HOLD_MAX(8)) dut (
        .sysCLK (sysCLK),
        .sysRST (sysRST),
        .bus    (bus.slave)
    );

    // RAM model: registered address, data the cycle after the access
    logic [DW-1:0] ram [0:65535];
    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = {16'hA5A5, 16'(i)};
    end
    always @(posedge sysCLK) begin
        if (bus.memRW) ram[bus.memAddr] <= bus.memDataW;
        bus.memDataR <= ram[bus.memAddr];
    end

    typedef struct {
        int            due;
        bit            isDbg;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          expQ[$];
    logic [DW-1:0] shadow [int];
    int            nChecks = 0;
    int            nPass   = 0;
    int            cycNo   = 0;

    function automatic logic [DW-1:0] expData(input logic [AW-1:0] a);
        if (shadow.exists(int'(a))) return shadow[int'(a)];
        return {16'hA5A5, a};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        assert (obs === exp) nPass++;
        else $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cycNo, obs, exp);
    endtask

    task automatic setCpu(input bit req, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.cpuReq = req; bus.cpuWE = we; bus.cpuAddr = a; bus.cpuWData = d;
    endtask

    task automatic setDbg(input bit req, input bit we, input bit hold, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.dbgReq = req; bus.dbgWE = we; bus.dbgHold = hold; bus.dbgAddr = a; bus.dbgWData = d;
    endtask

    // One clock cycle: check grants, memory drive and read return, then record expectations
    task automatic cyc(input bit eC, input bit eD);
        exp_t e;
        bit   rst;
        @(negedge sysCLK);
        rst = sysRST;
        chk("cpuGnt", bus.cpuGnt, eC);
        chk("dbgGnt", bus.dbgGnt, eD);
        chk("memRW", bus.memRW, eC ? bus.cpuWE : (eD ? bus.dbgWE : 1'b0));
        if (!rst) begin
            chk("memAddr", bus.memAddr, eD ? bus.dbgAddr : bus.cpuAddr);
            chk("memDataW", bus.memDataW, eD ? bus.dbgWData : bus.cpuWData);
        end
        if (expQ.size() > 0 && expQ[0].due == cycNo) begin
            e = expQ.pop_front();
            if (rst) begin
                chk("cpuRValid_rst", bus.cpuRValid, 1'b0);
                chk("dbgRValid_rst", bus.dbgRValid, 1'b0);
            end else begin
                chk("cpuRValid", bus.cpuRValid, !e.isDbg);
                chk("dbgRValid", bus.dbgRValid, e.isDbg);
                chk(e.isDbg ? "dbgRData" : "cpuRData", e.isDbg ? bus.dbgRData : bus.cpuRData, e.data);
            end
        end else begin
            chk("cpuRValid_idle", bus.cpuRValid, 1'b0);
            chk("dbgRValid_idle", bus.dbgRValid, 1'b0);
        end
        if (!rst && eC) begin
            if (bus.cpuWE) shadow[int'(bus.cpuAddr)] = bus.cpuWData;
            else expQ.push_back('{cycNo + 1, 1'b0, expData(bus.cpuAddr)});
        end
        if (!rst && eD) begin
            if (bus.dbgWE) shadow[int'(bus.dbgAddr)] = bus.dbgWData;
            else expQ.push_back('{cycNo + 1, 1'b1, expData(bus.dbgAddr)});
        end
        @(posedge sysCLK);
        #1;
        cycNo++;
    endtask

    initial begin
        setCpu(1'b0, 1'b0, 16'h0, 32'h0);
        setDbg(1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
        sysRST = 1'b1;
        cyc(0, 0);
        setCpu(1'b1, 1'b1, 16'h0077, 32'h1111_2222);
        setDbg(1'b1, 1'b1, 1'b0, 16'h0078, 32'h3333_4444);
        cyc(0, 0);
        sysRST = 1'b0;

        // CPU store then load of the same word
        setDbg(1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
        setCpu(1'b1, 1'b1, 16'h0010, 32'hDEAD_BEEF);
        cyc(1, 0);
        setCpu(1'b1, 1'b0, 16'h0010, 32'h0);
        cyc(1, 0);
        setCpu(1'b0, 1'b0, 16'h0010, 32'h0);
        cyc(0, 0);

        // Round-robin alternation from IDLE
        sysRST = 1'b1;
        cyc(0, 0);
        sysRST = 1'b0;
        setCpu(1'b1, 1'b0, 16'h0020, 32'h0);
        setDbg(1'b1, 1'b0, 1'b0, 16'h0030, 32'h0);
        cyc(1, 0);
        cyc(0, 1);
        cyc(1, 0);
        cyc(0, 1);
        setCpu(1'b0, 1'b0, 16'h0, 32'h0);
        setDbg(1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
        cyc(0, 0);

        // Debug write followed immediately by CPU read of the same address
        setDbg(1'b1, 1'b1, 1'b0, 16'h0003, 32'h1234_5678);
        cyc(0, 1);
        setDbg(1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
        setCpu(1'b1, 1'b0, 16'h0003, 32'h0);
        cyc(1, 0);
        setCpu(1'b0, 1'b0, 16'h0, 32'h0);
        cyc(0, 0);

        // Hold mode: debug gets HOLD_MAX grants while CPU waits, then CPU
        setDbg(1'b1, 1'b0, 1'b1, 16'h0040, 32'h0);
        cyc(0, 1);
        setCpu(1'b1, 1'b0, 16'h0050, 32'h0);
        repeat (8) cyc(0, 1);
        cyc(1, 0);
        cyc(0, 1);
        setCpu(1'b0, 1'b0, 16'h0, 32'h0);

        // Hold with no CPU demand: counter must not advance
        repeat (20) cyc(0, 1);
        setCpu(1'b1, 1'b0, 16'h0060, 32'h0);
        repeat (8) cyc(0, 1);
        cyc(1, 0);
        setCpu(1'b0, 1'b0, 16'h0, 32'h0);
        setDbg(1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
        cyc(0, 0);

        // Reset right after a read grant swallows the return
        setCpu(1'b1, 1'b0, 16'h0010, 32'h0);
        cyc(1, 0);
        sysRST = 1'b1;
        setDbg(1'b1, 1'b0, 1'b0, 16'h0041, 32'h0);
        cyc(0, 0);
        cyc(0, 0);
        sysRST = 1'b0;
        cyc(1, 0);
        cyc(0, 1);
        setCpu(1'b0, 1'b0, 16'h0, 32'h0);
        setDbg(1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
        cyc(0, 0);
        cyc(0, 0);

        chk("queue_drained", 64'(expQ.size()), 64'd0);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
